traffic_light_4way_adaptive: RTL and testbench



---
 rtl/traffic_light_4way_adaptive.sv | 193 +++++++++++++++++++
 tb/tb_traffic_light_4way_adaptive.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_4way_adaptive.sv
// Adaptive 4-way intersection controller: per-phase timers, on-demand protected right turns,
// emergency preemption and night flash. Lamps are one-hot: red=100, yellow=010, green=001.
module traffic_light_4way_adaptive #(
   parameter int GREEN_T  = 8,
   parameter int YELLOW_T = 3,
   parameter int TURN_T   = 4,
   parameter int ALLRED_T = 2,
   parameter int FLASH_T  = 4,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       rt_req,
   input  logic             emg_req,
   input  logic             emg_axis,
   input  logic             flash_en,
   output logic [2:0]       north_light,
   output logic [2:0]       south_light,
   output logic [2:0]       east_light,
   output logic [2:0]       west_light,
   output logic             north_left_arrow,
   output logic             south_left_arrow,
   output logic             east_left_arrow,
   output logic             west_left_arrow,
   output logic             north_right_arrow,
   output logic             south_right_arrow,
   output logic             east_right_arrow,
   output logic             west_right_arrow,
   output logic [4:0]       state,
   output logic [CNT_W-1:0] counter
);

   typedef enum logic [4:0] {
      NS_GO  = 5'd0,  NS_Y   = 5'd1,  N_RT   = 5'd2,  N_RT_Y   = 5'd3,  S_RT  = 5'd4,
      S_RT_Y = 5'd5,  AR_NS  = 5'd6,  EW_GO  = 5'd7,  EW_Y     = 5'd8,  E_RT  = 5'd9,
      E_RT_Y = 5'd10, W_RT   = 5'd11, W_RT_Y = 5'd12, AR_EW    = 5'd13, PRE_Y = 5'd14,
      PRE_AR = 5'd15, PRE_GO = 5'd16, PRE_EXIT = 5'd17, FLASH  = 5'd18
   } state_t;

   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_rt, r_mask, w_mask, w_gmask, w_rt_clr;
   logic             r_fph, r_emg_prev, r_emg_axis;
   logic             w_emg_rise, w_axis, w_done, w_enter;

   function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
      case (s)
         NS_GO, EW_GO:                                   return CNT_W'(GREEN_T - 1);
         N_RT, S_RT, E_RT, W_RT:                         return CNT_W'(TURN_T - 1);
         AR_NS, AR_EW, PRE_AR:                           return CNT_W'(ALLRED_T - 1);
         FLASH:                                          return CNT_W'(FLASH_T - 1);
         NS_Y, N_RT_Y, S_RT_Y, EW_Y, E_RT_Y, W_RT_Y,
         PRE_Y, PRE_EXIT:                                return CNT_W'(YELLOW_T - 1);
         default:                                        return '0;
      endcase
   endfunction

   // Approaches showing green in a state, {W,E,S,N}; zero for non-green states.
   function automatic logic [3:0] green_mask(input state_t s);
      case (s)
         NS_GO:   return 4'b0011;
         N_RT:    return 4'b0001;
         S_RT:    return 4'b0010;
         EW_GO:   return 4'b1100;
         E_RT:    return 4'b0100;
         W_RT:    return 4'b1000;
         default: return 4'b0000;
      endcase
   endfunction

   // A rise during PRE_EXIT is deferred so the exiting axis cannot change under the yellow lamps.
   assign w_emg_rise = emg_req && !r_emg_prev && (r_state != PRE_EXIT);
   assign w_axis     = w_emg_rise ? emg_axis : r_emg_axis;
   assign w_done     = (r_cnt == '0);
   assign w_gmask    = green_mask(r_state);
   assign w_enter    = (w_next != r_state);
   assign w_rt_clr   = {4{w_enter}} & {w_next == W_RT, w_next == E_RT, w_next == S_RT, w_next == N_RT};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= NS_GO;
         r_cnt      <= dur_m1(NS_GO);
         r_rt       <= '0;
         r_mask     <= '0;
         r_fph      <= 1'b0;
         r_emg_prev <= 1'b0;
         r_emg_axis <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_emg_prev <= emg_req && (r_state != PRE_EXIT);
         r_rt       <= (r_rt | rt_req) & ~w_rt_clr;
         r_mask     <= w_mask;
         if (w_emg_rise) r_emg_axis <= emg_axis;
         if (w_enter)                         r_cnt <= dur_m1(w_next);
         else if (r_state == PRE_GO)          r_cnt <= '0;
         else if (r_state == FLASH && w_done) r_cnt <= dur_m1(FLASH);
         else                                 r_cnt <= r_cnt - 1'b1;
         if (w_enter && w_next == FLASH)      r_fph <= 1'b0;
         else if (r_state == FLASH && w_done) r_fph <= ~r_fph;
      end
   end

   always_comb begin
      w_next = r_state;
      w_mask = r_mask;
      if (emg_req && (|w_gmask)) begin
         // Green on the cross axis must clear through yellow; green on the emergency axis is kept.
         if ((|w_gmask[1:0]) == w_axis) begin
            w_next = PRE_Y;
            w_mask = w_gmask;
         end else begin
            w_next = PRE_GO;
         end
      end else begin
         case (r_state)
            NS_GO:    if (w_done) w_next = NS_Y;
            NS_Y:     if (w_done) w_next = emg_req ? PRE_AR : r_rt[0] ? N_RT : r_rt[1] ? S_RT : AR_NS;
            N_RT:     if (w_done) w_next = N_RT_Y;
            N_RT_Y:   if (w_done) w_next = emg_req ? PRE_AR : r_rt[1] ? S_RT : AR_NS;
            S_RT:     if (w_done) w_next = S_RT_Y;
            S_RT_Y:   if (w_done) w_next = emg_req ? PRE_AR : AR_NS;
            AR_NS:    if (w_done) w_next = emg_req ? PRE_AR : flash_en ? FLASH : EW_GO;
            EW_GO:    if (w_done) w_next = EW_Y;
            EW_Y:     if (w_done) w_next = emg_req ? PRE_AR : r_rt[2] ? E_RT : r_rt[3] ? W_RT : AR_EW;
            E_RT:     if (w_done) w_next = E_RT_Y;
            E_RT_Y:   if (w_done) w_next = emg_req ? PRE_AR : r_rt[3] ? W_RT : AR_EW;
            W_RT:     if (w_done) w_next = W_RT_Y;
            W_RT_Y:   if (w_done) w_next = emg_req ? PRE_AR : AR_EW;
            AR_EW:    if (w_done) w_next = emg_req ? PRE_AR : flash_en ? FLASH : NS_GO;
            FLASH:    if (emg_req) w_next = PRE_AR;
                      else if (w_done && !flash_en) w_next = AR_EW;
            PRE_Y:    if (w_done) w_next = PRE_AR;
            PRE_AR:   if (w_done) w_next = PRE_GO;
            PRE_GO:   if (!emg_req) w_next = PRE_EXIT;
            PRE_EXIT: if (w_done) w_next = r_emg_axis ? AR_EW : AR_NS;
            default:  w_next = NS_GO;
         endcase
      end
   end

   always_comb begin
      north_light       = LAMP_R;
      south_light       = LAMP_R;
      east_light        = LAMP_R;
      west_light        = LAMP_R;
      north_right_arrow = 1'b0;
      south_right_arrow = 1'b0;
      east_right_arrow  = 1'b0;
      west_right_arrow  = 1'b0;
      case (r_state)
         NS_GO:    begin north_light = LAMP_G; south_light = LAMP_G; end
         NS_Y:     begin north_light = LAMP_Y; south_light = LAMP_Y; end
         N_RT:     begin north_light = LAMP_G; north_right_arrow = 1'b1; end
         N_RT_Y:   north_light = LAMP_Y;
         S_RT:     begin south_light = LAMP_G; south_right_arrow = 1'b1; end
         S_RT_Y:   south_light = LAMP_Y;
         EW_GO:    begin east_light = LAMP_G; west_light = LAMP_G; end
         EW_Y:     begin east_light = LAMP_Y; west_light = LAMP_Y; end
         E_RT:     begin east_light = LAMP_G; east_right_arrow = 1'b1; end
         E_RT_Y:   east_light = LAMP_Y;
         W_RT:     begin west_light = LAMP_G; west_right_arrow = 1'b1; end
         W_RT_Y:   west_light = LAMP_Y;
         PRE_Y: begin
            if (r_mask[0]) north_light = LAMP_Y;
            if (r_mask[1]) south_light = LAMP_Y;
            if (r_mask[2]) east_light  = LAMP_Y;
            if (r_mask[3]) west_light  = LAMP_Y;
         end
         PRE_GO: begin
            if (r_emg_axis) begin east_light = LAMP_G; west_light = LAMP_G; end
            else begin north_light = LAMP_G; south_light = LAMP_G; end
         end
         PRE_EXIT: begin
            if (r_emg_axis) begin east_light = LAMP_Y; west_light = LAMP_Y; end
            else begin north_light = LAMP_Y; south_light = LAMP_Y; end
         end
         FLASH:    if (r_fph) begin north_light = LAMP_Y; south_light = LAMP_Y; end
         default:  ;
      endcase
   end

   assign north_left_arrow = (north_light == LAMP_G);
   assign south_left_arrow = (south_light == LAMP_G);
   assign east_left_arrow  = (east_light  == LAMP_G);
   assign west_left_arrow  = (west_light  == LAMP_G);
   assign state            = r_state;
   assign counter          = r_cnt;

endmodule

// File: tb/tb_traffic_light_4way_adaptive.sv
// Scenario bench for traffic_light_4way_adaptive: expected per-cycle state/lamps/arrows/counter
// are queued from the intended phase sequence and popped one per clock.
module tb_traffic_light_4way_adaptive;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;

   localparam logic [4:0] S_NS_GO = 5'd0,  S_NS_Y = 5'd1,  S_N_RT = 5'd2,  S_N_RT_Y = 5'd3;
   localparam logic [4:0] S_S_RT = 5'd4,   S_S_RT_Y = 5'd5, S_AR_NS = 5'd6, S_EW_GO = 5'd7;
   localparam logic [4:0] S_EW_Y = 5'd8,   S_E_RT = 5'd9,  S_E_RT_Y = 5'd10, S_W_RT = 5'd11;
   localparam logic [4:0] S_W_RT_Y = 5'd12, S_AR_EW = 5'd13, S_PRE_Y = 5'd14, S_PRE_AR = 5'd15;
   localparam logic [4:0] S_PRE_GO = 5'd16, S_PRE_EXIT = 5'd17, S_FLASH = 5'd18;

   typedef struct {
      logic [4:0]  st;
      logic [11:0] lamps;
      logic [7:0]  arr;
      logic [7:0]  cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, emg_req, emg_axis, flash_en;
   logic [3:0] rt_req;
   logic [2:0] north_light, south_light, east_light, west_light;
   logic       nl, sl, el, wl, nr, sr, er, wr;
   logic [4:0] d_state;
   logic [7:0] d_counter;
   logic [11:0] w_lamps;
   logic [7:0]  w_arr;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic mon_en   = 1'b0;

   traffic_light_4way_adaptive #(
      .GREEN_T(8), .YELLOW_T(3), .TURN_T(4), .ALLRED_T(2), .FLASH_T(4), .CNT_W(8)
   ) dut (
      .clk(clk), .reset(reset), .rt_req(rt_req), .emg_req(emg_req), .emg_axis(emg_axis),
      .flash_en(flash_en),
      .north_light(north_light), .south_light(south_light),
      .east_light(east_light), .west_light(west_light),
      .north_left_arrow(nl), .south_left_arrow(sl), .east_left_arrow(el), .west_left_arrow(wl),
      .north_right_arrow(nr), .south_right_arrow(sr), .east_right_arrow(er), .west_right_arrow(wr),
      .state(d_state), .counter(d_counter)
   );

   always #5 clk = ~clk;

   assign w_lamps = {north_light, south_light, east_light, west_light};
   assign w_arr   = {nl, sl, el, wl, nr, sr, er, wr};

   // Safety invariants, sampled every falling edge once the design has been reset.
   always @(negedge clk) begin
      if (mon_en) begin
         n_checks++;
         if ((((north_light !== R) || (south_light !== R)) && ((east_light !== R) || (west_light !== R))) ||
             (north_light === 3'b000) || (south_light === 3'b000) ||
             (east_light === 3'b000) || (west_light === 3'b000) ||
             (nr && south_light !== R) || (sr && north_light !== R) ||
             (er && west_light !== R) || (wr && east_light !== R)) begin
            n_fail++;
            $display("FAIL safety t=%0t: lamps=%h arrows=%b, required no collision/blackout/unsafe arrow",
                     $time, w_lamps, w_arr);
         end
      end
   end

   task automatic push_seg(input logic [4:0] st, input logic [11:0] lamps, input logic [3:0] ra,
                           input int len, input int cut);
      exp_t e;
      for (int i = 0; i < cut; i++) begin
         e.st    = st;
         e.lamps = lamps;
         e.arr   = {lamps[11:9] == G, lamps[8:6] == G, lamps[5:3] == G, lamps[2:0] == G, ra};
         e.cnt   = (st == S_PRE_GO) ? 8'd0 : 8'(len - 1 - i);
         q.push_back(e);
      end
   endtask

   task automatic do_reset();
      rt_req = 4'b0; emg_req = 1'b0; emg_axis = 1'b0; flash_en = 1'b0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      q.delete();
   endtask

   task automatic test_reset();
      exp_t e;
      do_reset();
      mon_en = 1'b1;
      push_seg(S_NS_GO, {G,G,R,R}, 4'b0, 8, 8);
      push_seg(S_NS_Y,  {Y,Y,R,R}, 4'b0, 3, 3);
      push_seg(S_AR_NS, {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_EW_GO, {R,R,G,G}, 4'b0, 8, 8);
      push_seg(S_EW_Y,  {R,R,Y,Y}, 4'b0, 3, 3);
      push_seg(S_AR_EW, {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_NS_GO, {G,G,R,R}, 4'b0, 8, 8);
      for (int k = 0; q.size() > 0; k++) begin
         @(negedge clk);
         e = q.pop_front();
         n_checks++;
         if ({d_state, w_lamps, w_arr, d_counter} !== {e.st, e.lamps, e.arr, e.cnt}) begin
            n_fail++;
            $display("FAIL reset_cycle k=%0d: got st=%0d lamps=%h arr=%b cnt=%0d, expected st=%0d lamps=%h arr=%b cnt=%0d",
                     k, d_state, w_lamps, w_arr, d_counter, e.st, e.lamps, e.arr, e.cnt);
         end
      end
   endtask

   task automatic test_rt_single();
      exp_t e;
      do_reset();
      push_seg(S_NS_GO,  {G,G,R,R}, 4'b0,    8, 8);
      push_seg(S_NS_Y,   {Y,Y,R,R}, 4'b0,    3, 3);
      push_seg(S_N_RT,   {G,R,R,R}, 4'b1000, 4, 4);
      push_seg(S_N_RT_Y, {Y,R,R,R}, 4'b0,    3, 3);
      push_seg(S_AR_NS,  {R,R,R,R}, 4'b0,    2, 2);
      push_seg(S_EW_GO,  {R,R,G,G}, 4'b0,    8, 8);
      push_seg(S_EW_Y,   {R,R,Y,Y}, 4'b0,    3, 3);
      push_seg(S_AR_EW,  {R,R,R,R}, 4'b0,    2, 2);
      push_seg(S_NS_GO,  {G,G,R,R}, 4'b0,    8, 8);
      push_seg(S_NS_Y,   {Y,Y,R,R}, 4'b0,    3, 3);
      push_seg(S_AR_NS,  {R,R,R,R}, 4'b0,    2, 2);
      for (int k = 0; q.size() > 0; k++) begin
         @(negedge clk);
         e = q.pop_front();
         n_checks++;
         if ({d_state, w_lamps, w_arr, d_counter} !== {e.st, e.lamps, e.arr, e.cnt}) begin
            n_fail++;
            $display("FAIL rt_single k=%0d: got st=%0d lamps=%h arr=%b cnt=%0d, expected st=%0d lamps=%h arr=%b cnt=%0d",
                     k, d_state, w_lamps, w_arr, d_counter, e.st, e.lamps, e.arr, e.cnt);
         end
         rt_req = (k == 2) ? 4'b0001 : 4'b0000;
      end
   endtask

   task automatic test_rt_multi();
      exp_t e;
      do_reset();
      push_seg(S_NS_GO,  {G,G,R,R}, 4'b0,    8, 8);
      push_seg(S_NS_Y,   {Y,Y,R,R}, 4'b0,    3, 3);
      push_seg(S_N_RT,   {G,R,R,R}, 4'b1000, 4, 4);
      push_seg(S_N_RT_Y, {Y,R,R,R}, 4'b0,    3, 3);
      push_seg(S_S_RT,   {R,G,R,R}, 4'b0100, 4, 4);
      push_seg(S_S_RT_Y, {R,Y,R,R}, 4'b0,    3, 3);
      push_seg(S_AR_NS,  {R,R,R,R}, 4'b0,    2, 2);
      push_seg(S_EW_GO,  {R,R,G,G}, 4'b0,    8, 8);
      push_seg(S_EW_Y,   {R,R,Y,Y}, 4'b0,    3, 3);
      push_seg(S_E_RT,   {R,R,G,R}, 4'b0010, 4, 4);
      push_seg(S_E_RT_Y, {R,R,Y,R}, 4'b0,    3, 3);
      push_seg(S_W_RT,   {R,R,R,G}, 4'b0001, 4, 4);
      push_seg(S_W_RT_Y, {R,R,R,Y}, 4'b0,    3, 3);
      push_seg(S_AR_EW,  {R,R,R,R}, 4'b0,    2, 2);
      push_seg(S_NS_GO,  {G,G,R,R}, 4'b0,    8, 8);
      for (int k = 0; q.size() > 0; k++) begin
         @(negedge clk);
         e = q.pop_front();
         n_checks++;
         if ({d_state, w_lamps, w_arr, d_counter} !== {e.st, e.lamps, e.arr, e.cnt}) begin
            n_fail++;
            $display("FAIL rt_multi k=%0d: got st=%0d lamps=%h arr=%b cnt=%0d, expected st=%0d lamps=%h arr=%b cnt=%0d",
                     k, d_state, w_lamps, w_arr, d_counter, e.st, e.lamps, e.arr, e.cnt);
         end
         rt_req = (k == 1) ? 4'b0011 : (k == 5) ? 4'b1100 : 4'b0000;
      end
   endtask

   task automatic test_emg_cross();
      exp_t e;
      do_reset();
      push_seg(S_NS_GO,    {G,G,R,R}, 4'b0, 8, 3);
      push_seg(S_PRE_Y,    {Y,Y,R,R}, 4'b0, 3, 3);
      push_seg(S_PRE_AR,   {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_PRE_GO,   {R,R,G,G}, 4'b0, 10, 10);
      push_seg(S_PRE_EXIT, {R,R,Y,Y}, 4'b0, 3, 3);
      push_seg(S_AR_EW,    {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_NS_GO,    {G,G,R,R}, 4'b0, 8, 8);
      for (int k = 0; q.size() > 0; k++) begin
         @(negedge clk);
         e = q.pop_front();
         n_checks++;
         if ({d_state, w_lamps, w_arr, d_counter} !== {e.st, e.lamps, e.arr, e.cnt}) begin
            n_fail++;
            $display("FAIL emg_cross k=%0d: got st=%0d lamps=%h arr=%b cnt=%0d, expected st=%0d lamps=%h arr=%b cnt=%0d",
                     k, d_state, w_lamps, w_arr, d_counter, e.st, e.lamps, e.arr, e.cnt);
         end
         emg_req  = (k >= 2 && k < 17);
         emg_axis = (k >= 2 && k < 4);
      end
   endtask

   task automatic test_emg_yellow();
      exp_t e;
      do_reset();
      push_seg(S_NS_GO,    {G,G,R,R}, 4'b0, 8, 8);
      push_seg(S_NS_Y,     {Y,Y,R,R}, 4'b0, 3, 3);
      push_seg(S_PRE_AR,   {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_PRE_GO,   {G,G,R,R}, 4'b0, 4, 4);
      push_seg(S_PRE_EXIT, {Y,Y,R,R}, 4'b0, 3, 3);
      push_seg(S_AR_NS,    {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_EW_GO,    {R,R,G,G}, 4'b0, 8, 8);
      for (int k = 0; q.size() > 0; k++) begin
         @(negedge clk);
         e = q.pop_front();
         n_checks++;
         if ({d_state, w_lamps, w_arr, d_counter} !== {e.st, e.lamps, e.arr, e.cnt}) begin
            n_fail++;
            $display("FAIL emg_yellow k=%0d: got st=%0d lamps=%h arr=%b cnt=%0d, expected st=%0d lamps=%h arr=%b cnt=%0d",
                     k, d_state, w_lamps, w_arr, d_counter, e.st, e.lamps, e.arr, e.cnt);
         end
         emg_req  = (k >= 9 && k < 16);
         emg_axis = 1'b0;
      end
   endtask

   task automatic test_flash();
      exp_t e;
      do_reset();
      push_seg(S_NS_GO,    {G,G,R,R}, 4'b0, 8, 8);
      push_seg(S_NS_Y,     {Y,Y,R,R}, 4'b0, 3, 3);
      push_seg(S_AR_NS,    {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_EW_GO,    {R,R,G,G}, 4'b0, 8, 8);
      push_seg(S_EW_Y,     {R,R,Y,Y}, 4'b0, 3, 3);
      push_seg(S_AR_EW,    {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_FLASH,    {R,R,R,R}, 4'b0, 4, 4);
      push_seg(S_FLASH,    {Y,Y,R,R}, 4'b0, 4, 4);
      push_seg(S_FLASH,    {R,R,R,R}, 4'b0, 4, 4);
      push_seg(S_AR_EW,    {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_NS_GO,    {G,G,R,R}, 4'b0, 8, 8);
      push_seg(S_NS_Y,     {Y,Y,R,R}, 4'b0, 3, 3);
      push_seg(S_AR_NS,    {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_FLASH,    {R,R,R,R}, 4'b0, 4, 4);
      push_seg(S_FLASH,    {Y,Y,R,R}, 4'b0, 4, 2);
      push_seg(S_PRE_AR,   {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_PRE_GO,   {G,G,R,R}, 4'b0, 2, 2);
      push_seg(S_PRE_EXIT, {Y,Y,R,R}, 4'b0, 3, 3);
      push_seg(S_AR_NS,    {R,R,R,R}, 4'b0, 2, 2);
      push_seg(S_EW_GO,    {R,R,G,G}, 4'b0, 8, 8);
      for (int k = 0; q.size() > 0; k++) begin
         @(negedge clk);
         e = q.pop_front();
         n_checks++;
         if ({d_state, w_lamps, w_arr, d_counter} !== {e.st, e.lamps, e.arr, e.cnt}) begin
            n_fail++;
            $display("FAIL flash k=%0d: got st=%0d lamps=%h arr=%b cnt=%0d, expected st=%0d lamps=%h arr=%b cnt=%0d",
                     k, d_state, w_lamps, w_arr, d_counter, e.st, e.lamps, e.arr, e.cnt);
         end
         flash_en = (k >= 14 && k < 35) || (k >= 41 && k < 58);
         emg_req  = (k >= 58 && k < 62);
         emg_axis = 1'b0;
      end
   endtask

   task automatic test_reset_midop();
      exp_t e;
      do_reset();
      push_seg(S_NS_GO,  {G,G,R,R}, 4'b0,    8, 1);
      push_seg(S_PRE_Y,  {Y,Y,R,R}, 4'b0,    3, 3);
      push_seg(S_PRE_AR, {R,R,R,R}, 4'b0,    2, 2);
      push_seg(S_PRE_GO, {R,R,G,G}, 4'b0,    2, 2);
      push_seg(S_NS_GO,  {G,G,R,R}, 4'b0,    8, 8);
      push_seg(S_NS_Y,   {Y,Y,R,R}, 4'b0,    3, 3);
      push_seg(S_AR_NS,  {R,R,R,R}, 4'b0,    2, 2);
      push_seg(S_EW_GO,  {R,R,G,G}, 4'b0,    8, 8);
      push_seg(S_EW_Y,   {R,R,Y,Y}, 4'b0,    3, 3);
      push_seg(S_E_RT,   {R,R,G,R}, 4'b0010, 4, 2);
      push_seg(S_NS_GO,  {G,G,R,R}, 4'b0,    8, 8);
      push_seg(S_NS_Y,   {Y,Y,R,R}, 4'b0,    3, 3);
      push_seg(S_AR_NS,  {R,R,R,R}, 4'b0,    2, 2);
      push_seg(S_EW_GO,  {R,R,G,G}, 4'b0,    8, 8);
      push_seg(S_EW_Y,   {R,R,Y,Y}, 4'b0,    3, 3);
      push_seg(S_AR_EW,  {R,R,R,R}, 4'b0,    2, 2);
      for (int k = 0; q.size() > 0; k++) begin
         @(negedge clk);
         e = q.pop_front();
         n_checks++;
         if ({d_state, w_lamps, w_arr, d_counter} !== {e.st, e.lamps, e.arr, e.cnt}) begin
            n_fail++;
            $display("FAIL reset_midop k=%0d: got st=%0d lamps=%h arr=%b cnt=%0d, expected st=%0d lamps=%h arr=%b cnt=%0d",
                     k, d_state, w_lamps, w_arr, d_counter, e.st, e.lamps, e.arr, e.cnt);
         end
         emg_req  = (k < 7);
         emg_axis = (k < 7);
         reset    = (k == 7) || (k == 33);
         rt_req   = (k == 22) ? 4'b0101 : 4'b0000;
      end
   endtask

   initial begin
      rt_req = 4'b0; emg_req = 1'b0; emg_axis = 1'b0; flash_en = 1'b0; reset = 1'b1;
      test_reset();
      test_rt_single();
      test_rt_multi();
      test_emg_cross();
      test_emg_yellow();
      test_flash();
      test_reset_midop();
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
